picobello_offload_int_reducer: RTL
==================================

Name: picobello_offload_int_reducer

Overview:
- Synthesizable integer reduction unit on the tile's offload reduction port of the FlooNoC router.
- Consumes one two-operand reduction request per handshake and returns one result per request, in order.
- Sits directly downstream of the router's offload request interface and drives the offload response interface; the simulation offload logger monitors both sides.
- Implements the integer and select opcodes of reduction_op_t. Float opcodes are rejected with an error flag.

Parameters:
- DataWidth, 64, operand/result width in bits; must be a multiple of MulStepBits.
- MulStepBits, 4, multiplier bits consumed per cycle by the iterative multiplier.
- data_t, logic [DataWidth-1:0], operand/result type.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- offload_req_operands_i  in  2 x DataWidth  operands [1] and [0]
- offload_req_operation_i  in  4  reduction_op_t opcode
- offload_req_valid_i  in  1  request valid
- offload_req_ready_o  out  1  request ready
- offload_resp_result_o  out  DataWidth  result
- offload_resp_error_o  out  1  unsupported opcode flag, valid with result
- offload_resp_valid_o  out  1  response valid
- offload_resp_ready_i  in  1  response ready
- busy_o  out  1  state != IDLE

Behaviour:
- Opcodes (4-bit):
  - 0 R_Select: result = operands[0].
  - 8 A_Add: sum of both operands, mod 2^DataWidth.
  - 9 A_Mul: low DataWidth bits of the product.
  - 10 A_Min_S, 11 A_Max_S: signed two's-complement compare.
  - 14 A_Min_U, 15 A_Max_U: unsigned compare.
  - Any other code (1-7, 12, 13): result 0, error 1, single-cycle path.
- FSM states IDLE, MUL, RESP. Reset: state IDLE, result 0, error 0, resp_valid 0, busy 0, multiplier registers 0.
- Request accept (fire = valid_i & ready_o):
  - ready_o = (state==IDLE) | (state==RESP & resp_ready_i). Combinational from resp_ready_i; no other comb path from inputs to outputs.
  - Non-mul fire: result and error registered, next state RESP. Latency is 1 cycle (resp_valid asserted the cycle after fire).
  - Mul fire: load multiplicand = operands[1], multiplier = operands[0], accumulator = 0, step counter = 0, next state MUL.
- MUL state:
  - Each cycle adds multiplicand * multiplier[MulStepBits-1:0] to the accumulator, shifts the multiplicand left by MulStepBits and the multiplier right by MulStepBits, and increments the counter.
  - After DataWidth/MulStepBits cycles (16 at defaults), latch the accumulator into result and go to RESP.
  - Mul latency = DataWidth/MulStepBits + 1 cycles from fire to resp_valid.
  - ready_o = 0 throughout MUL.
- RESP state:
  - resp_valid_o = 1. Result and error are held stable until resp_ready_i; valid never drops without a handshake.
  - Response handshake with no new request: go to IDLE.
  - Response handshake with a simultaneous new request fire: back-to-back. New non-mul → stay RESP with the new result next cycle. New mul → MUL. Single-op throughput is 1 per cycle.
- Operands and opcode are sampled only on fire; later changes while busy are ignored.
- Reset mid-operation (any state): immediately returns to IDLE with all outputs at reset values; the in-flight request is lost.
- At most one request is outstanding; responses are strictly in order.

Decomposition:
- Shared package (picobello_pkg): reduction_op_t opcode localparams (RSelect=0, AAdd=8, AMul=9, AMinS=10, AMaxS=11, AMinU=14, AMaxU=15) and a helper function is_int_reduction_op().
- One sub-module: picobello_iter_multiplier
  - Holds the MUL datapath, counter and done pulse.
  - Interface: start, operands, done, product.
  - Parameters: DataWidth, MulStepBits.
- Compare/add/select logic stays inline in the top module.

Test Plan:
- A_Add, operands 0xFFFF_FFFF_FFFF_FFFF and 2, resp_ready held 1 → result 1, error 0, resp_valid exactly 1 cycle after fire.
- A_Min_S / A_Min_U on operands 0x8000_0000_0000_0000 and 5 → signed result 0x8000_0000_0000_0000, unsigned result 5. A_Max_S / A_Max_U on the same operands → 5 and 0x8000_0000_0000_0000.
- A_Mul, operands 0x1_0000_0003 and 0x1_0000_0005 → result 0x0000_0008_0000_000F. resp_valid exactly 17 cycles after fire; ready_o low during all 16 MUL cycles.
- Back-to-back stream of 8 A_Add requests, resp_ready always 1 → one response per cycle, in order. Then resp_ready held 0 for 5 cycles → result stable, ready_o 0, no request lost.
- Opcode 4 (F_Add) → result 0, error 1, 1-cycle latency. A following R_Select with operands[0]=42 → result 42, error 0.
- rst_ni asserted at MUL cycle 7 → resp_valid 0 and busy_o 0 immediately. After release, an A_Add 3+4 → result 7.

Source files
------------

// File: rtl/picobello_pkg.sv
// Opcode encodings and FSM state type shared by the offload integer reduction unit.
package picobello_pkg;

    typedef logic [3:0] reduction_op_t;

    localparam reduction_op_t RSelect = 4'd0;
    localparam reduction_op_t AAdd    = 4'd8;
    localparam reduction_op_t AMul    = 4'd9;
    localparam reduction_op_t AMinS   = 4'd10;
    localparam reduction_op_t AMaxS   = 4'd11;
    localparam reduction_op_t AMinU   = 4'd14;
    localparam reduction_op_t AMaxU   = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StResp
    } reducer_state_e;

    function automatic logic is_int_reduction_op(input reduction_op_t op);
        logic supported;
        unique case (op)
            RSelect, AAdd, AMul, AMinS, AMaxS, AMinU, AMaxU: supported = 1'b1;
            default:                                         supported = 1'b0;
        endcase
        return supported;
    endfunction

endpackage

// File: rtl/picobello_iter_multiplier.sv
// Iterative shift-add multiplier: consumes MulStepBits multiplier bits per cycle and
// pulses done_o in the cycle whose product_o carries the final low DataWidth bits.
module picobello_iter_multiplier #(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned MulStepBits = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DataWidth-1:0] multiplicand_i,
    input  logic [DataWidth-1:0] multiplier_i,
    output logic                 done_o,
    output logic [DataWidth-1:0] product_o
);

    localparam int unsigned NumSteps = DataWidth / MulStepBits;
    localparam int unsigned CntWidth = (NumSteps > 1) ? $clog2(NumSteps) : 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumSteps - 1);

    logic [DataWidth-1:0] mcand_q, mcand_d;
    logic [DataWidth-1:0] mplier_q, mplier_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 active_q, active_d;

    logic [DataWidth-1:0] partial;
    logic [DataWidth-1:0] acc_next;
    logic                 last_step;

    assign partial   = mcand_q * DataWidth'(mplier_q[MulStepBits-1:0]);
    assign acc_next  = acc_q + partial;
    assign last_step = active_q & (cnt_q == LastCnt);

    // The final step's sum is handed out combinationally so the caller can latch it
    // on the same edge, keeping the latency at NumSteps cycles in the MUL state.
    assign done_o    = last_step;
    assign product_o = acc_next;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            mcand_d  = multiplicand_i;
            mplier_d = multiplier_i;
            acc_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            mcand_d  = mcand_q << MulStepBits;
            mplier_d = mplier_q >> MulStepBits;
            acc_d    = acc_next;
            cnt_d    = cnt_q + 1'b1;
            active_d = ~last_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/picobello_offload_int_reducer.sv
// Integer reduction unit on the router offload port: one two-operand request in,
// one in-order result out; float opcodes return zero with the error flag set.
module picobello_offload_int_reducer
    import picobello_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned MulStepBits = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [2*DataWidth-1:0] offload_req_operands_i,
    input  logic [3:0]             offload_req_operation_i,
    input  logic                   offload_req_valid_i,
    output logic                   offload_req_ready_o,
    output logic [DataWidth-1:0]   offload_resp_result_o,
    output logic                   offload_resp_error_o,
    output logic                   offload_resp_valid_o,
    input  logic                   offload_resp_ready_i,
    output logic                   busy_o
);

    typedef logic [DataWidth-1:0] data_t;

    reducer_state_e state_q, state_d;
    data_t          result_q, result_d;
    logic           error_q, error_d;

    data_t         op_a, op_b;
    reduction_op_t opcode;
    data_t         alu_result;
    logic          fire;
    logic          mul_start;
    logic          mul_done;
    data_t         mul_product;

    assign op_a   = offload_req_operands_i[DataWidth-1:0];
    assign op_b   = offload_req_operands_i[2*DataWidth-1:DataWidth];
    assign opcode = offload_req_operation_i;

    assign offload_req_ready_o   = (state_q == StIdle) |
                                   ((state_q == StResp) & offload_resp_ready_i);
    assign fire                  = offload_req_valid_i & offload_req_ready_o;
    assign offload_resp_valid_o  = (state_q == StResp);
    assign offload_resp_result_o = result_q;
    assign offload_resp_error_o  = error_q;
    assign busy_o                = (state_q != StIdle);

    always_comb begin
        alu_result = '0;
        case (opcode)
            RSelect: alu_result = op_a;
            AAdd:    alu_result = op_a + op_b;
            AMinS:   alu_result = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
            AMaxS:   alu_result = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
            AMinU:   alu_result = (op_a < op_b) ? op_a : op_b;
            AMaxU:   alu_result = (op_a > op_b) ? op_a : op_b;
            default: alu_result = '0;
        endcase
    end

    picobello_iter_multiplier #(
        .DataWidth   (DataWidth),
        .MulStepBits (MulStepBits)
    ) u_mul (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (mul_start),
        .multiplicand_i (op_b),
        .multiplier_i   (op_a),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        error_d   = error_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle, StResp: begin
                if ((state_q == StResp) && offload_resp_ready_i) begin
                    state_d = StIdle;
                end
                // A fire in StResp implies the current response is also handshaken.
                if (fire) begin
                    if (opcode == AMul) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        result_d = alu_result;
                        error_d  = ~is_int_reduction_op(opcode);
                        state_d  = StResp;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    result_d = mul_product;
                    error_d  = 1'b0;
                    state_d  = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

endmodule
